// File: rtl/toeplitz_hash_serial.sv
// Chunk-serial GF(2) Toeplitz hash: 256-bit tweak absorbed CHUNK bits per beat into a 128-bit hash.
// Optional macro TOEPLITZ_ZKEY_ERR_EN: an all-zero key is rejected with a one-cycle err pulse.

module toeplitz_hash_lane #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] key_win,
  input  logic [CHUNK-1:0] data,
  output logic             bit_out
);
  assign bit_out = ^(key_win & data);
endmodule

module toeplitz_hash_serial #(
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [382:0]     key_in,
  output logic             busy,
  input  logic             t_valid,
  output logic             t_ready,
  input  logic [CHUNK-1:0] t_data,
  output logic             h_valid,
  input  logic             h_ready,
  output logic [127:0]     h_data,
  output logic             err
);
  localparam int IN    = 256;
  localparam int DIM   = 128;
  localparam int KLEN  = IN + DIM - 1;
  localparam int NBEAT = IN / CHUNK;
  localparam int CW    = $clog2(NBEAT) + 1;
  localparam logic [CW-1:0] LAST = CW'(NBEAT - 1);

  typedef enum logic [1:0] {IDLE, ABSORB, DONE} state_t;

  state_t          state, state_nx;
  logic [KLEN-1:0] kreg;
  logic [DIM-1:0]  acc;
  logic [DIM-1:0]  contrib;
  logic [CW-1:0]   cnt;
  logic            beat;
  logic            key_ok;
  logic            err_q;

`ifdef TOEPLITZ_ZKEY_ERR_EN
  assign key_ok = |key_in;
`else
  assign key_ok = 1'b1;
`endif

  assign beat = t_valid && (state == ABSORB);

  // Lane k sees the key window starting at 127-k; shifting kreg right by CHUNK
  // per beat makes the same window line up with the next tweak chunk.
  for (genvar k = 0; k < DIM; k++) begin : g_lane
    toeplitz_hash_lane #(.CHUNK(CHUNK)) u_lane (
      .key_win (kreg[DIM-1-k +: CHUNK]),
      .data    (t_data),
      .bit_out (contrib[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start && key_ok)      state_nx = ABSORB;
      ABSORB:  if (beat && cnt == LAST)  state_nx = DONE;
      DONE:    if (h_ready)              state_nx = IDLE;
      default:                           state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != IDLE);
    t_ready = (state == ABSORB);
    h_valid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      kreg <= '0;
      acc  <= '0;
      cnt  <= '0;
    end else if (state == IDLE && start && key_ok) begin
      kreg <= key_in;
      acc  <= '0;
      cnt  <= '0;
    end else if (beat) begin
      acc  <= acc ^ contrib;
      kreg <= kreg >> CHUNK;
      cnt  <= cnt + 1'b1;
    end
  end

`ifdef TOEPLITZ_ZKEY_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= (state == IDLE) && start && !key_ok;
  end
`else
  assign err_q = 1'b0;
`endif

  assign h_data = acc;
  assign err    = err_q;
endmodule

// File: tb/tb_toeplitz_hash_serial.sv
// Randomized scoreboard bench for toeplitz_hash_serial at CHUNK = 8, 1 and 256 side by side.
// Expected hashes come from the direct formula hash[k] = XOR_j key[127-k+j] & tweak[j].
`timescale 1ns/1ps
module tb_toeplitz_hash_serial;
  localparam int NCFG  = 3;
  localparam int NRAND = 67;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic logic [127:0] ref_hash(input logic [382:0] key, input logic [255:0] tw);
    logic [127:0] h;
    h = '0;
    for (int k = 0; k < 128; k++)
      for (int j = 0; j < 256; j++)
        h[k] = h[k] ^ (key[127-k+j] & tw[j]);
    return h;
  endfunction

  function automatic logic [383:0] rnd_wide();
    logic [383:0] r;
    for (int i = 0; i < 12; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int C  = (g == 0) ? 8 : (g == 1) ? 1 : 256;
    localparam int NB = 256 / C;

    logic           rst, start, busy, t_valid, t_ready, h_valid, h_ready, err;
    logic [382:0]   key_in;
    logic [C-1:0]   t_data;
    logic [127:0]   h_data;
    logic [127:0]   exp_q[$];
    logic           fin = 1'b0;

    toeplitz_hash_serial #(.CHUNK(C)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .key_in  (key_in),
      .busy    (busy),
      .t_valid (t_valid),
      .t_ready (t_ready),
      .t_data  (t_data),
      .h_valid (h_valid),
      .h_ready (h_ready),
      .h_data  (h_data),
      .err     (err)
    );

    function automatic string nm(input string s);
      return $sformatf("c%0d_%s", C, s);
    endfunction

    // Monitor: every hash handed off must match the oldest outstanding expectation.
    always @(negedge clk) begin
      if (!rst && h_valid && h_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL %s: actual=%h required=no hash outstanding", nm("unexpected_hash"), h_data);
        end else begin
          check(nm("hash"), h_data, exp_q.pop_front());
        end
      end
    end

    // mode: 0 t_valid always high, 1 toggling, 2 random. abort >= 0 resets after that many beats.
    task automatic run_hash(input logic [382:0] key, input logic [255:0] tw, input logic [127:0] exp,
                            input int mode, input int hold, input int abort);
      int   b, guard, cyc, w;
      logic acc_b;
      exp_q.push_back(exp);
      h_ready = (hold == 0);
      start = 1'b1;
      key_in = key;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 1; b = 0; guard = 0;
      while (b < NB && b != abort && guard < 4000) begin
        t_valid = (mode == 0) ? 1'b1 : (mode == 1) ? ~guard[0] : ($urandom_range(3) != 0);
        t_data  = tw[b*C +: C];
        @(negedge clk);
        acc_b = t_valid & t_ready;
        @(posedge clk); #1;
        if (acc_b) b++;
        guard++;
        cyc++;
      end
      t_valid = 1'b0;
      if (abort >= 0) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        void'(exp_q.pop_back());
        @(negedge clk);
        check(nm("abort_busy"),    128'(busy),    128'(0));
        check(nm("abort_t_ready"), 128'(t_ready), 128'(0));
        check(nm("abort_h_valid"), 128'(h_valid), 128'(0));
        check(nm("abort_h_data"),  h_data,        128'(0));
        check(nm("abort_err"),     128'(err),     128'(0));
        @(posedge clk); #1;
        return;
      end
      check(nm("beats_accepted"), 128'(b), 128'(NB));
      w = 0;
      @(negedge clk);
      while (!h_valid && w < 50) begin
        @(posedge clk); #1;
        cyc++;
        w++;
        @(negedge clk);
      end
      check(nm("done_seen"), 128'(h_valid), 128'(1));
      if (mode == 0) check(nm("latency"), 128'(cyc), 128'(NB + 1));
      if (hold > 0) begin
        for (int i = 0; i < hold; i++) begin
          check(nm("hold_valid"), 128'(h_valid), 128'(1));
          check(nm("hold_data"),  h_data,        exp);
          @(posedge clk); #1;
          start  = 1'b1;
          key_in = ~key;
          if (i == hold - 1) h_ready = 1'b1;
          @(negedge clk);
        end
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check(nm("idle_after_start_in_done"), 128'({busy, t_ready}), 128'(0));
      end
      @(posedge clk); #1;
    endtask

    initial begin
      logic [383:0] r;
      logic [382:0] key, k127;
      logic [255:0] tw;
      int           hold;
      rst = 1'b1; start = 1'b0; t_valid = 1'b0; h_ready = 1'b1;
      key_in = '0; t_data = '0;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      check(nm("rst_busy"),    128'(busy),    128'(0));
      check(nm("rst_t_ready"), 128'(t_ready), 128'(0));
      check(nm("rst_h_valid"), 128'(h_valid), 128'(0));
      check(nm("rst_h_data"),  h_data,        128'(0));
      check(nm("rst_err"),     128'(err),     128'(0));
      @(posedge clk); #1;
      rst = 1'b0;

      run_hash('1, 256'h1, '1, 0, 0, -1);
      k127 = '0;
      k127[127] = 1'b1;
      run_hash(k127, 256'h1, 128'h1, 0, 0, -1);
      run_hash(k127, 256'h2, 128'h2, 0, 0, -1);
      run_hash(k127, 256'h1 << 255, 128'h0, 0, 0, -1);

      r = rnd_wide(); key = r[382:0];
      r = rnd_wide(); tw = r[255:0];
      run_hash(key, tw, ref_hash(key, tw), 1, 0, -1);
      run_hash(key, tw, ref_hash(key, tw), 0, 5, -1);
      run_hash(key, tw, ref_hash(key, tw), 0, 0, (NB > 10) ? 10 : NB - 1);
      r = rnd_wide(); key = r[382:0];
      run_hash(key, tw, ref_hash(key, tw), 0, 0, -1);

`ifdef TOEPLITZ_ZKEY_ERR_EN
      start = 1'b1;
      key_in = '0;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check(nm("zkey_err_pulse"), 128'(err),     128'(1));
      check(nm("zkey_t_ready"),   128'(t_ready), 128'(0));
      check(nm("zkey_busy"),      128'(busy),    128'(0));
      @(posedge clk); #1;
      @(negedge clk);
      check(nm("zkey_err_end"),   128'(err),     128'(0));
      check(nm("zkey_t_ready2"),  128'(t_ready), 128'(0));
      @(posedge clk); #1;
`else
      run_hash('0, tw, 128'h0, 0, 0, -1);
`endif

      for (int n = 0; n < NRAND; n++) begin
        r = rnd_wide(); key = r[382:0];
        r = rnd_wide(); tw = r[255:0];
        hold = ($urandom_range(3) == 0) ? int'($urandom_range(3, 1)) : 0;
        run_hash(key, tw, ref_hash(key, tw), 2, hold, -1);
      end
      fin = 1'b1;
    end
  end

  initial begin
    int t;
    t = 0;
    while (!(g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin) && t < 90000) begin
      @(posedge clk);
      t++;
    end
    if (t >= 90000) begin
      checks++;
      errors++;
      $display("FAIL run_timeout: actual=%0d cycles required=all drivers finished", t);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
